rf_wb_queue: RTL and testbench
==============================

Name: rf_wb_queue

Overview:
- Write-side driver for the 32x32 register file.
- Collects writeback results from the ALU and the load/store unit through valid/ready handshakes and buffers them in a small in-order FIFO.
- Drains the FIFO into the register file write port (A3/WD3/WE), one write per cycle.
- Provides forwarding lookups so decode can read results that are still queued and not yet committed.

Parameters:
- DEPTH, 4, number of queue entries; power of two, minimum 2.
- AW, 5, register address width.
- DW, 32, data width.

Ports:
- CLK  in  1  system clock; all state updates on posedge.
- RST  in  1  synchronous, active-high reset.
- ALU_VLD  in  1  ALU result valid.
- ALU_RD  in  AW  ALU destination register.
- ALU_WD  in  DW  ALU result data.
- ALU_RDY  out  1  queue accepts the ALU result this cycle.
- LSU_VLD  in  1  load result valid.
- LSU_RD  in  AW  load destination register.
- LSU_WD  in  DW  load data.
- LSU_RDY  out  1  queue accepts the load result this cycle.
- WB_STALL  in  1  blocks draining this cycle (register file port in use elsewhere).
- A3  out  AW  register file write address.
- WD3  out  DW  register file write data.
- WE  out  1  register file write enable.
- RA1  in  AW  decode read address 1 (same value as the register file A1).
- RA2  in  AW  decode read address 2.
- FWD1_HIT  out  1  RA1 matches a queued entry.
- FWD1_D  out  DW  forwarded data for RA1.
- FWD2_HIT  out  1  RA2 matches a queued entry.
- FWD2_D  out  DW  forwarded data for RA2.
- OCC  out  $clog2(DEPTH)+1  current entry count.

Behaviour:
- Storage: circular FIFO with rd_ptr, wr_ptr and count; entry = {rd, wd}. Pointers wrap modulo DEPTH.
- Acceptance:
  - At most one push per cycle.
  - LSU has fixed priority over ALU.
  - LSU_RDY = (count < DEPTH).
  - ALU_RDY = (count < DEPTH) & ~LSU_VLD.
  - Push occurs on posedge when VLD & RDY.
  - No push when full, even if a pop happens in the same cycle.
  - RDY never depends on WB_STALL.
- x0 filtering: a result with rd == 0 is handshaken normally (RDY as above) but is not enqueued, and count does not change.
- Drain:
  - A3 = head.rd and WD3 = head.wd, combinational from the head entry.
  - WE = (count != 0) & ~WB_STALL.
  - Pop on posedge when WE = 1.
- Latency: a result accepted at edge N is on A3/WD3/WE during cycle N..N+1 and is written to the register file at edge N+1, provided there is no stall and the queue was empty.
- Simultaneous push and pop: count is unchanged, both pointers advance, and this is legal at any count below DEPTH.
- Ordering: strict FIFO. Multiple entries with the same rd commit oldest first, so the register file ends with the youngest value.
- Forwarding (combinational):
  - Search all valid entries for rd == RAx, with RAx != 0.
  - The youngest match wins, so FWDx_D is the newest pending value.
  - On no match, HIT = 0 and D = 0.
  - The entry being popped this cycle still counts as a hit; the register file has not updated yet.
  - The entry being pushed this cycle is not visible until the next cycle.
- Reset (synchronous, CLK edge with RST = 1):
  - count, rd_ptr and wr_ptr cleared to 0.
  - Resulting outputs: WE = 0, OCC = 0, FWDx_HIT = 0, A3 = 0, WD3 = 0 (head gated to 0 when empty).
  - ALU_RDY/LSU_RDY are 1 after reset, gated by LSU_VLD for ALU_RDY.
  - Reset mid-operation discards all queued entries without writing them.
  - While RST = 1, WE is forced to 0 combinationally.
- Empty: WE = 0 and A3/WD3 = 0. Full: both RDY = 0.

Decomposition:
- Shared package rv_pkg holds: REG_AW = 5, XLEN = 32, REG_X0 = 5'd0, and the typedef wb_entry_t {rd, wd}.
- Sub-module rf_wb_fwd_lookup: combinational youngest-match priority search over the FIFO entries. It is instantiated twice, once per read port.
- FIFO control stays in rf_wb_queue.

Test Plan:
- Reset, then ALU_VLD = 1 with RD = 5, WD = 0xDEADBEEF for one cycle → next cycle WE = 1, A3 = 5, WD3 = 0xDEADBEEF; OCC returns to 0 after the following edge.
- LSU (RD = 3, 0x11) and ALU (RD = 4, 0x22) valid in the same cycle → LSU_RDY = 1 and ALU_RDY = 0; LSU is written first, ALU is accepted the next cycle.
- WB_STALL held high while pushing 5 results → OCC reaches 4, both RDY = 0 on the 5th; releasing the stall drains 4 writes in order on 4 consecutive cycles.
- Queue RD = 7/0xA then RD = 7/0xB under stall, RA1 = 7 → FWD1_HIT = 1, FWD1_D = 0xB; RA2 = 0 → FWD2_HIT = 0.
- ALU push with RD = 0, WD = 0xFFFF → ALU_RDY = 1, OCC stays 0, WE never asserts.
- Fill 3 entries under stall, then assert RST for one cycle → OCC = 0, WE = 0, no writes issued after the stall is released.

Source files
------------

// File: rtl/rv_pkg.sv
// Register-file shared types: address/data widths and the writeback entry record.
package rv_pkg;
  localparam int REG_AW = 5;
  localparam int XLEN   = 32;
  localparam logic [REG_AW-1:0] REG_X0 = 5'd0;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   wd;
  } wb_entry_t;
endpackage

// File: rtl/rf_wb_fwd_lookup.sv
// Youngest-match search over queue entries presented oldest-first (index 0 = head).
module rf_wb_fwd_lookup #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic [DEPTH-1:0]         vld,
  input  logic [DEPTH-1:0][AW-1:0] rd,
  input  logic [DEPTH-1:0][DW-1:0] wd,
  input  logic [AW-1:0]            ra,
  output logic                     hit,
  output logic [DW-1:0]            d
);
  // Later (younger) matches overwrite earlier ones.
  always_comb begin
    hit = 1'b0;
    d   = '0;
    if (ra != '0) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (vld[i] && rd[i] == ra) begin
          hit = 1'b1;
          d   = wd[i];
        end
      end
    end
  end
endmodule

// File: rtl/rf_wb_queue.sv
// Writeback queue: arbitrates LSU/ALU results into an in-order FIFO that drains
// into the register file write port, with forwarding of still-pending results.
module rf_wb_queue
  import rv_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = REG_AW,
  parameter int DW    = XLEN
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       ALU_VLD,
  input  logic [AW-1:0]              ALU_RD,
  input  logic [DW-1:0]              ALU_WD,
  output logic                       ALU_RDY,
  input  logic                       LSU_VLD,
  input  logic [AW-1:0]              LSU_RD,
  input  logic [DW-1:0]              LSU_WD,
  output logic                       LSU_RDY,
  input  logic                       WB_STALL,
  output logic [AW-1:0]              A3,
  output logic [DW-1:0]              WD3,
  output logic                       WE,
  input  logic [AW-1:0]              RA1,
  input  logic [AW-1:0]              RA2,
  output logic                       FWD1_HIT,
  output logic [DW-1:0]              FWD1_D,
  output logic                       FWD2_HIT,
  output logic [DW-1:0]              FWD2_D,
  output logic [$clog2(DEPTH):0]     OCC
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_entry_t        mem [DEPTH];
  logic [PW-1:0]    rd_ptr, wr_ptr;
  logic [CW-1:0]    count;
  logic             full, empty, lsu_acc, alu_acc, push, pop;
  wb_entry_t        push_e, head;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign LSU_RDY = ~full;
  assign ALU_RDY = ~full & ~LSU_VLD;
  assign lsu_acc = LSU_VLD & LSU_RDY;
  assign alu_acc = ALU_VLD & ALU_RDY;

  assign push_e.rd = lsu_acc ? LSU_RD : ALU_RD;
  assign push_e.wd = lsu_acc ? LSU_WD : ALU_WD;
  // x0 results complete the handshake but never occupy a slot.
  assign push = (lsu_acc | alu_acc) & (push_e.rd != REG_X0);

  assign WE   = ~empty & ~WB_STALL & ~RST;
  assign pop  = WE;
  assign head = mem[rd_ptr];
  assign A3   = empty ? '0 : head.rd;
  assign WD3  = empty ? '0 : head.wd;
  assign OCC  = count;

  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (push && !RST) mem[wr_ptr] <= push_e;
  end

  // Entries re-ordered by age so the lookup can apply last-match-wins.
  logic [DEPTH-1:0]         ord_vld;
  logic [DEPTH-1:0][AW-1:0] ord_rd;
  logic [DEPTH-1:0][DW-1:0] ord_wd;

  for (genvar i = 0; i < DEPTH; i++) begin : g_ord
    logic [PW-1:0] idx;
    assign idx        = rd_ptr + PW'(i);
    assign ord_vld[i] = (CW'(i) < count);
    assign ord_rd[i]  = mem[idx].rd;
    assign ord_wd[i]  = mem[idx].wd;
  end

  rf_wb_fwd_lookup #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fwd1 (
    .vld(ord_vld), .rd(ord_rd), .wd(ord_wd), .ra(RA1), .hit(FWD1_HIT), .d(FWD1_D)
  );

  rf_wb_fwd_lookup #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fwd2 (
    .vld(ord_vld), .rd(ord_rd), .wd(ord_wd), .ra(RA2), .hit(FWD2_HIT), .d(FWD2_D)
  );
endmodule

// File: tb/tb_rf_wb_queue.sv
// Directed per-cycle vector bench for rf_wb_queue (DEPTH=4).
module tb_rf_wb_queue;
  logic        CLK, RST;
  logic        ALU_VLD, LSU_VLD, WB_STALL;
  logic [4:0]  ALU_RD, LSU_RD, RA1, RA2, A3;
  logic [31:0] ALU_WD, LSU_WD, WD3, FWD1_D, FWD2_D;
  logic        ALU_RDY, LSU_RDY, WE, FWD1_HIT, FWD2_HIT;
  logic [2:0]  OCC;

  rf_wb_queue #(.DEPTH(4), .AW(5), .DW(32)) dut (
    .CLK(CLK), .RST(RST),
    .ALU_VLD(ALU_VLD), .ALU_RD(ALU_RD), .ALU_WD(ALU_WD), .ALU_RDY(ALU_RDY),
    .LSU_VLD(LSU_VLD), .LSU_RD(LSU_RD), .LSU_WD(LSU_WD), .LSU_RDY(LSU_RDY),
    .WB_STALL(WB_STALL), .A3(A3), .WD3(WD3), .WE(WE),
    .RA1(RA1), .RA2(RA2),
    .FWD1_HIT(FWD1_HIT), .FWD1_D(FWD1_D), .FWD2_HIT(FWD2_HIT), .FWD2_D(FWD2_D),
    .OCC(OCC)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        rst, av;
    logic [4:0]  ard;
    logic [31:0] awd;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] lwd;
    logic        st;
    logic [4:0]  ra1, ra2;
    logic        ardy, lrdy, we;
    logic [4:0]  a3;
    logic [31:0] wd3;
    logic [2:0]  occ;
    logic        h1;
    logic [31:0] d1;
    logic        h2;
    logic [31:0] d2;
  } vec_t;

  vec_t tv[$];
  int total = 0;
  int bad   = 0;

  function automatic vec_t mk(
    input logic rst, av, input logic [4:0] ard, input logic [31:0] awd,
    input logic lv, input logic [4:0] lrd, input logic [31:0] lwd,
    input logic st, input logic [4:0] ra1, ra2,
    input logic ardy, lrdy, we, input logic [4:0] a3, input logic [31:0] wd3,
    input logic [2:0] occ, input logic h1, input logic [31:0] d1,
    input logic h2, input logic [31:0] d2);
    vec_t v;
    v.rst = rst; v.av = av; v.ard = ard; v.awd = awd;
    v.lv = lv; v.lrd = lrd; v.lwd = lwd; v.st = st; v.ra1 = ra1; v.ra2 = ra2;
    v.ardy = ardy; v.lrdy = lrdy; v.we = we; v.a3 = a3; v.wd3 = wd3;
    v.occ = occ; v.h1 = h1; v.d1 = d1; v.h2 = h2; v.d2 = d2;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL v%0d %s got=%h want=%h", idx, nm, act, exp);
    end
  endtask

  initial begin
    RST = 1'b1; ALU_VLD = 0; ALU_RD = 0; ALU_WD = 0;
    LSU_VLD = 0; LSU_RD = 0; LSU_WD = 0; WB_STALL = 0; RA1 = 0; RA2 = 0;

    //          rst av ard awd          lv lrd lwd   st ra1 ra2 | ardy lrdy we a3 wd3          occ h1 d1           h2 d2
    tv.push_back(mk(0,0, 0,0,           0,0,0,       0, 5,0,      1,1,0, 0,0,           0, 0,0,           0,0));
    tv.push_back(mk(0,1, 5,32'hDEADBEEF,0,0,0,       0, 5,0,      1,1,0, 0,0,           0, 0,0,           0,0));
    tv.push_back(mk(0,0, 0,0,           0,0,0,       0, 5,0,      1,1,1, 5,32'hDEADBEEF,1, 1,32'hDEADBEEF,0,0));
    tv.push_back(mk(0,0, 0,0,           0,0,0,       0, 5,0,      1,1,0, 0,0,           0, 0,0,           0,0));
    // LSU wins over ALU, ALU goes next cycle while the LSU result drains
    tv.push_back(mk(0,1, 4,32'h22,      1,3,32'h11,  0, 0,0,      0,1,0, 0,0,           0, 0,0,           0,0));
    tv.push_back(mk(0,1, 4,32'h22,      0,0,0,       0, 0,0,      1,1,1, 3,32'h11,      1, 0,0,           0,0));
    tv.push_back(mk(0,0, 0,0,           0,0,0,       0, 0,0,      1,1,1, 4,32'h22,      1, 0,0,           0,0));
    // fill under stall, fifth push refused, then drain in order
    tv.push_back(mk(0,1, 1,32'h101,     0,0,0,       1, 0,0,      1,1,0, 0,0,           0, 0,0,           0,0));
    tv.push_back(mk(0,1, 2,32'h102,     0,0,0,       1, 0,0,      1,1,0, 1,32'h101,     1, 0,0,           0,0));
    tv.push_back(mk(0,1, 3,32'h103,     0,0,0,       1, 0,0,      1,1,0, 1,32'h101,     2, 0,0,           0,0));
    tv.push_back(mk(0,1, 4,32'h104,     0,0,0,       1, 0,0,      1,1,0, 1,32'h101,     3, 0,0,           0,0));
    tv.push_back(mk(0,1, 5,32'h105,     0,0,0,       1, 0,0,      0,0,0, 1,32'h101,     4, 0,0,           0,0));
    tv.push_back(mk(0,1, 5,32'h105,     0,0,0,       0, 0,0,      0,0,1, 1,32'h101,     4, 0,0,           0,0));
    tv.push_back(mk(0,0, 0,0,           0,0,0,       0, 0,0,      1,1,1, 2,32'h102,     3, 0,0,           0,0));
    tv.push_back(mk(0,0, 0,0,           0,0,0,       0, 0,0,      1,1,1, 3,32'h103,     2, 0,0,           0,0));
    tv.push_back(mk(0,0, 0,0,           0,0,0,       0, 0,0,      1,1,1, 4,32'h104,     1, 0,0,           0,0));
    tv.push_back(mk(0,0, 0,0,           0,0,0,       0, 0,0,      1,1,0, 0,0,           0, 0,0,           0,0));
    // same rd queued twice: youngest value forwarded
    tv.push_back(mk(0,1, 7,32'hA,       0,0,0,       1, 7,0,      1,1,0, 0,0,           0, 0,0,           0,0));
    tv.push_back(mk(0,1, 7,32'hB,       0,0,0,       1, 7,0,      1,1,0, 7,32'hA,       1, 1,32'hA,       0,0));
    tv.push_back(mk(0,0, 0,0,           0,0,0,       1, 7,7,      1,1,0, 7,32'hA,       2, 1,32'hB,       1,32'hB));
    tv.push_back(mk(0,0, 0,0,           0,0,0,       0, 7,0,      1,1,1, 7,32'hA,       2, 1,32'hB,       0,0));
    tv.push_back(mk(0,0, 0,0,           0,0,0,       0, 7,0,      1,1,1, 7,32'hB,       1, 1,32'hB,       0,0));
    tv.push_back(mk(0,0, 0,0,           0,0,0,       0, 7,0,      1,1,0, 0,0,           0, 0,0,           0,0));
    // x0 result: handshaken, not queued
    tv.push_back(mk(0,1, 0,32'hFFFF,    0,0,0,       0, 0,0,      1,1,0, 0,0,           0, 0,0,           0,0));
    tv.push_back(mk(0,0, 0,0,           0,0,0,       0, 0,0,      1,1,0, 0,0,           0, 0,0,           0,0));
    // reset with 3 queued entries discards them
    tv.push_back(mk(0,1, 9,32'h201,     0,0,0,       1, 9,0,      1,1,0, 0,0,           0, 0,0,           0,0));
    tv.push_back(mk(0,1,10,32'h202,     0,0,0,       1, 9,0,      1,1,0, 9,32'h201,     1, 1,32'h201,     0,0));
    tv.push_back(mk(0,1,11,32'h203,     0,0,0,       1, 9,0,      1,1,0, 9,32'h201,     2, 1,32'h201,     0,0));
    tv.push_back(mk(1,0, 0,0,           0,0,0,       0, 9,0,      1,1,0, 9,32'h201,     3, 1,32'h201,     0,0));
    tv.push_back(mk(0,0, 0,0,           0,0,0,       0, 9,0,      1,1,0, 0,0,           0, 0,0,           0,0));
    tv.push_back(mk(0,0, 0,0,           0,0,0,       0, 9,0,      1,1,0, 0,0,           0, 0,0,           0,0));

    repeat (2) @(posedge CLK);
    for (int i = 0; i < tv.size(); i++) begin
      @(negedge CLK);
      RST = tv[i].rst; ALU_VLD = tv[i].av; ALU_RD = tv[i].ard; ALU_WD = tv[i].awd;
      LSU_VLD = tv[i].lv; LSU_RD = tv[i].lrd; LSU_WD = tv[i].lwd;
      WB_STALL = tv[i].st; RA1 = tv[i].ra1; RA2 = tv[i].ra2;
      #1;
      chk("alu_rdy",  i, 32'(ALU_RDY),  32'(tv[i].ardy));
      chk("lsu_rdy",  i, 32'(LSU_RDY),  32'(tv[i].lrdy));
      chk("we",       i, 32'(WE),       32'(tv[i].we));
      chk("a3",       i, 32'(A3),       32'(tv[i].a3));
      chk("wd3",      i, WD3,           tv[i].wd3);
      chk("occ",      i, 32'(OCC),      32'(tv[i].occ));
      chk("fwd1_hit", i, 32'(FWD1_HIT), 32'(tv[i].h1));
      chk("fwd1_d",   i, FWD1_D,        tv[i].d1);
      chk("fwd2_hit", i, 32'(FWD2_HIT), 32'(tv[i].h2));
      chk("fwd2_d",   i, FWD2_D,        tv[i].d2);
    end
    @(negedge CLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
